// File: rtl/acs_trellis_seq.sv
// -----------------------------------------------------------------------------
// acs_trellis_seq
// Time-multiplexed add-compare-select engine for an N-state shift-register
// trellis (SOQPSK Viterbi path). One trellis state is processed per accepted
// branch-metric pair; old/new path metrics live in two ping-pong banks.
// Stored metrics are kept normalised: the minimum of the previous pass is
// subtracted while computing the next pass.
//
// Optional feature: define ACS_DECAY_EN to scale every selected metric by the
// Q0.8 gain decayFactor. Without it no multiplier is built and decayFactor is
// ignored.
//
// Ports
//   clk, reset    clock, asynchronous active-high reset
//   symEn         start-of-symbol pulse (accepted in IDLE)
//   bmValid       bm0/bm1 valid for state bmState
//   bm0, bm1      branch metrics from predecessors p0=(2s)%N, p1=(2s+1)%N
//   decayFactor   Q0.8 decay gain (ACS_DECAY_EN only)
//   busy          pass in progress (RUN or DONE)
//   bmState       state index the next bm pair is consumed for
//   decVec        survivor decisions, bit s for state s
//   decValid      one-cycle strobe, decVec/bestState/minMetric updated
//   bestState     index of the largest new metric (lowest index on ties)
//   minMetric     smallest new metric of the last pass
//   overrun       sticky: symEn seen while busy
// -----------------------------------------------------------------------------
module acs_trellis_seq #(
  parameter int NUM_STATES = 4,
  parameter int STATE_BITS = 2,
  parameter int METRIC_W   = 12,
  parameter int BM_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  symEn,
  input  logic                  bmValid,
  input  logic [BM_W-1:0]       bm0,
  input  logic [BM_W-1:0]       bm1,
  input  logic [7:0]            decayFactor,
  output logic                  busy,
  output logic [STATE_BITS-1:0] bmState,
  output logic [NUM_STATES-1:0] decVec,
  output logic                  decValid,
  output logic [STATE_BITS-1:0] bestState,
  output logic [METRIC_W-1:0]   minMetric,
  output logic                  overrun
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [STATE_BITS-1:0] LAST = STATE_BITS'(NUM_STATES - 1);

  state_t                  state_q, state_d;
  logic [STATE_BITS-1:0]   cnt_q, cnt_d;
  logic                    act_q, act_d;
  logic [METRIC_W-1:0]     norm_q, norm_d;
  logic [METRIC_W-1:0]     bank_q [2][NUM_STATES];
  logic [METRIC_W-1:0]     bank_d [2][NUM_STATES];
  logic [METRIC_W-1:0]     min_acc_q, min_acc_d;
  logic [METRIC_W-1:0]     best_val_q, best_val_d;
  logic [STATE_BITS-1:0]   best_idx_q, best_idx_d;
  logic [NUM_STATES-1:0]   dec_acc_q, dec_acc_d;
  logic [NUM_STATES-1:0]   dec_vec_q, dec_vec_d;
  logic [STATE_BITS-1:0]   best_state_q, best_state_d;
  logic [METRIC_W-1:0]     min_metric_q, min_metric_d;
  logic                    overrun_q, overrun_d;

  function automatic logic [METRIC_W-1:0] sat_metric(input logic [METRIC_W:0] v);
    return v[METRIC_W] ? {METRIC_W{1'b1}} : v[METRIC_W-1:0];
  endfunction

`ifdef ACS_DECAY_EN
  // Rounded Q0.8 scaling; the result never exceeds the input, so no re-saturation.
  function automatic logic [METRIC_W-1:0] decay_scale(input logic [METRIC_W-1:0] m,
                                                     input logic [7:0]          f);
    logic [METRIC_W+7:0] prod;
    prod = (METRIC_W+8)'(m) * (METRIC_W+8)'(f) + (METRIC_W+8)'(128);
    return prod[METRIC_W+7:8];
  endfunction
`endif

  // Predecessors of a shift-register trellis: drop the top index bit, shift in 0/1.
  logic [STATE_BITS:0]   two_s;
  logic [STATE_BITS-1:0] p0, p1;
  logic [METRIC_W:0]     c0, c1, sel;
  logic                  dec_bit;
  logic [METRIC_W-1:0]   new_metric;

  assign two_s = {cnt_q, 1'b0};
  assign p0    = two_s[STATE_BITS-1:0];
  assign p1    = p0 | STATE_BITS'(1);

  // old >= normOff always holds (normOff is the minimum stored value), so the
  // subtraction cannot go negative.
  assign c0 = (METRIC_W+1)'(bank_q[act_q][p0]) + (METRIC_W+1)'(bm0) - (METRIC_W+1)'(norm_q);
  assign c1 = (METRIC_W+1)'(bank_q[act_q][p1]) + (METRIC_W+1)'(bm1) - (METRIC_W+1)'(norm_q);
  assign dec_bit = (c1 > c0);
  assign sel     = dec_bit ? c1 : c0;

`ifdef ACS_DECAY_EN
  assign new_metric = decay_scale(sat_metric(sel), decayFactor);
`else
  logic unused_decay;
  assign unused_decay = ^decayFactor;
  assign new_metric   = sat_metric(sel);
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    act_d        = act_q;
    norm_d       = norm_q;
    bank_d       = bank_q;
    min_acc_d    = min_acc_q;
    best_val_d   = best_val_q;
    best_idx_d   = best_idx_q;
    dec_acc_d    = dec_acc_q;
    dec_vec_d    = dec_vec_q;
    best_state_d = best_state_q;
    min_metric_d = min_metric_q;
    overrun_d    = overrun_q | (symEn & (state_q != S_IDLE));
    unique case (state_q)
      S_IDLE: begin
        if (symEn) begin
          state_d    = S_RUN;
          cnt_d      = '0;
          min_acc_d  = {METRIC_W{1'b1}};
          best_val_d = '0;
          best_idx_d = '0;
          dec_acc_d  = '0;
        end
      end
      S_RUN: begin
        if (bmValid) begin
          bank_d[~act_q][cnt_q] = new_metric;
          dec_acc_d[cnt_q]      = dec_bit;
          if (new_metric < min_acc_q) min_acc_d = new_metric;
          if (new_metric > best_val_q) begin
            best_val_d = new_metric;
            best_idx_d = cnt_q;
          end
          cnt_d = cnt_q + STATE_BITS'(1);
          // Results are registered with the last pair so they are valid during DONE.
          if (cnt_q == LAST) begin
            state_d      = S_DONE;
            dec_vec_d    = dec_acc_d;
            best_state_d = best_idx_d;
            min_metric_d = min_acc_d;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        act_d   = ~act_q;
        norm_d  = min_acc_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      act_q        <= 1'b0;
      norm_q       <= '0;
      for (int b = 0; b < 2; b++)
        for (int s = 0; s < NUM_STATES; s++)
          bank_q[b][s] <= '0;
      min_acc_q    <= '0;
      best_val_q   <= '0;
      best_idx_q   <= '0;
      dec_acc_q    <= '0;
      dec_vec_q    <= '0;
      best_state_q <= '0;
      min_metric_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      act_q        <= act_d;
      norm_q       <= norm_d;
      bank_q       <= bank_d;
      min_acc_q    <= min_acc_d;
      best_val_q   <= best_val_d;
      best_idx_q   <= best_idx_d;
      dec_acc_q    <= dec_acc_d;
      dec_vec_q    <= dec_vec_d;
      best_state_q <= best_state_d;
      min_metric_q <= min_metric_d;
      overrun_q    <= overrun_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign decValid  = (state_q == S_DONE);
  assign bmState   = cnt_q;
  assign decVec    = dec_vec_q;
  assign bestState = best_state_q;
  assign minMetric = min_metric_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_acs_trellis_seq.sv
// -----------------------------------------------------------------------------
// tb_acs_trellis_seq
// Two instances share all inputs: a 12-bit metric build and a 9-bit metric
// build, the latter so that metric saturation is reachable with N=4.
// Expected results come from a pass-level reference model (max-select ACS with
// min normalisation, clamp and optional decay) plus hand-derived constants.
// -----------------------------------------------------------------------------
module tb_acs_trellis_seq;
  logic       clk = 1'b0;
  logic       reset, symEn, bmValid;
  logic [7:0] bm0, bm1, decayFactor;

  logic       busy_w, decValid_w, overrun_w;
  logic [1:0] bmState_w, bestState_w;
  logic [3:0] decVec_w;
  logic [11:0] minMetric_w;

  logic       busy_n, decValid_n, overrun_n;
  logic [1:0] bmState_n, bestState_n;
  logic [3:0] decVec_n;
  logic [8:0] minMetric_n;

  acs_trellis_seq #(.NUM_STATES(4), .STATE_BITS(2), .METRIC_W(12), .BM_W(8)) dut (
    .clk(clk), .reset(reset), .symEn(symEn), .bmValid(bmValid), .bm0(bm0), .bm1(bm1),
    .decayFactor(decayFactor), .busy(busy_w), .bmState(bmState_w), .decVec(decVec_w),
    .decValid(decValid_w), .bestState(bestState_w), .minMetric(minMetric_w),
    .overrun(overrun_w));

  acs_trellis_seq #(.NUM_STATES(4), .STATE_BITS(2), .METRIC_W(9), .BM_W(8)) dut_n (
    .clk(clk), .reset(reset), .symEn(symEn), .bmValid(bmValid), .bm0(bm0), .bm1(bm1),
    .decayFactor(decayFactor), .busy(busy_n), .bmState(bmState_n), .decVec(decVec_n),
    .decValid(decValid_n), .bestState(bestState_n), .minMetric(minMetric_n),
    .overrun(overrun_n));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: index 0 = 12-bit instance, 1 = 9-bit instance.
  int m_old [2][4];
  int m_norm[2];
  int m_max [2] = '{4095, 511};
  int pb0[4], pb1[4];
  int exp_dec[2], exp_best[2], exp_min[2];

  typedef struct {
    int b0;
    int b1;
    int dec;
    int mn;
    int best;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_norm[k] = 0;
      for (int s = 0; s < 4; s++) m_old[k][s] = 0;
    end
  endtask

  task automatic model_pass(input int k);
    int nw[4];
    int a, b, v, mn, bi;
    exp_dec[k] = 0;
    for (int s = 0; s < 4; s++) begin
      a = m_old[k][(2*s) % 4]     + pb0[s] - m_norm[k];
      b = m_old[k][(2*s + 1) % 4] + pb1[s] - m_norm[k];
      if (b > a) begin
        v = b;
        exp_dec[k] = exp_dec[k] | (1 << s);
      end else begin
        v = a;
      end
      if (v > m_max[k]) v = m_max[k];
`ifdef ACS_DECAY_EN
      v = (v * int'(decayFactor) + 128) / 256;
`endif
      nw[s] = v;
    end
    mn = nw[0];
    bi = 0;
    for (int s = 1; s < 4; s++) begin
      if (nw[s] < mn) mn = nw[s];
      if (nw[s] > nw[bi]) bi = s;
    end
    exp_min[k]  = mn;
    exp_best[k] = bi;
    for (int s = 0; s < 4; s++) m_old[k][s] = nw[s];
    m_norm[k] = mn;
  endtask

  task automatic set_uniform(input int b0, input int b1);
    for (int s = 0; s < 4; s++) begin
      pb0[s] = b0;
      pb1[s] = b1;
    end
  endtask

  task automatic apply_reset();
    symEn   = 1'b0;
    bmValid = 1'b0;
    reset   = 1'b1;
    #2;
    check("reset_busy_w", busy_w, 0);
    check("reset_busy_n", busy_n, 0);
    check("reset_decValid", decValid_w, 0);
    tick();
    reset = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic run_pass(input bit gaps, input bit inject);
    int pulses;
    pulses = 0;
    model_pass(0);
    model_pass(1);
    symEn = 1'b1;
    tick();
    symEn = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bmValid = 1'b0;
          tick();
          if (decValid_w) pulses++;
        end
      end
      bmValid = 1'b1;
      bm0     = 8'(pb0[s]);
      bm1     = 8'(pb1[s]);
      symEn   = inject && (s == 1);
      check("bmState", bmState_w, s);
      tick();
      symEn = 1'b0;
      if (s < 3 && decValid_w) pulses++;
    end
    bmValid = 1'b0;
    check("decValid_w", decValid_w, 1);
    check("decValid_n", decValid_n, 1);
    check("decVec_w", decVec_w, exp_dec[0]);
    check("bestState_w", bestState_w, exp_best[0]);
    check("minMetric_w", minMetric_w, exp_min[0]);
    check("decVec_n", decVec_n, exp_dec[1]);
    check("bestState_n", bestState_n, exp_best[1]);
    check("minMetric_n", minMetric_n, exp_min[1]);
    tick();
    check("decValid_one_cycle", decValid_w, 0);
    check("early_decValid", pulses, 0);
    check("busy_after_pass", busy_w, 0);
    tick();
    check("decVec_hold", decVec_w, exp_dec[0]);
    check("minMetric_hold", minMetric_w, exp_min[0]);
  endtask

  initial begin
    reset       = 1'b0;
    symEn       = 1'b0;
    bmValid     = 1'b0;
    bm0         = 8'd0;
    bm1         = 8'd0;
    decayFactor = 8'd128;

    tbl[0] = '{b0: 10, b1: 3,   dec: 0,  mn: 10,  best: 0};
    tbl[1] = '{b0: 0,  b1: 0,   dec: 0,  mn: 0,   best: 0};
    tbl[2] = '{b0: 7,  b1: 7,   dec: 0,  mn: 7,   best: 0};
    tbl[3] = '{b0: 0,  b1: 255, dec: 15, mn: 255, best: 0};
    tbl[4] = '{b0: 0,  b1: 255, dec: 15, mn: 255, best: 0};

    apply_reset();
    check("rst_decVec", decVec_w, 0);
    check("rst_minMetric", minMetric_w, 0);
    check("rst_bestState", bestState_w, 0);
    check("rst_overrun", overrun_w, 0);
    check("rst_bmState", bmState_w, 0);

`ifndef ACS_DECAY_EN
    for (int i = 0; i < 5; i++) begin
      set_uniform(tbl[i].b0, tbl[i].b1);
      run_pass(1'b0, 1'b0);
      check("tbl_decVec", decVec_w, tbl[i].dec);
      check("tbl_minMetric", minMetric_w, tbl[i].mn);
      check("tbl_bestState", bestState_w, tbl[i].best);
    end
    set_uniform(0, 255);
    for (int p = 0; p < 20; p++) begin
      run_pass(1'b0, 1'b0);
      check("bm1_max_decVec", decVec_w, 15);
      check("bm1_max_minMetric", minMetric_w, 255);
    end
`else
    apply_reset();
    decayFactor = 8'd128;
    set_uniform(10, 0);
    run_pass(1'b0, 1'b0);
    check("decay_half_min", minMetric_w, 5);
    decayFactor = 8'd0;
    set_uniform(200, 100);
    run_pass(1'b0, 1'b0);
    check("decay_zero_min", minMetric_w, 0);
    decayFactor = 8'd128;
`endif

    // Reset in the middle of a pass.
    apply_reset();
    set_uniform(10, 3);
    run_pass(1'b0, 1'b0);
    symEn = 1'b1;
    tick();
    symEn = 1'b0;
    for (int s = 0; s < 2; s++) begin
      bmValid = 1'b1;
      bm0     = 8'd10;
      bm1     = 8'd3;
      tick();
    end
    check("midpass_busy_before", busy_w, 1);
    apply_reset();
    repeat (3) begin
      tick();
      check("midpass_no_decValid", decValid_w, 0);
    end
    set_uniform(5, 0);
    run_pass(1'b0, 1'b0);
`ifndef ACS_DECAY_EN
    check("midpass_restart_min", minMetric_w, 5);
`endif

    // Drive the 9-bit instance into saturation and watch it change later passes.
    apply_reset();
    set_uniform(0, 0);
    pb0[0] = 255;
    for (int p = 0; p < 4; p++) run_pass(1'b0, 1'b0);
    set_uniform(0, 0);
    run_pass(1'b0, 1'b0);
`ifndef ACS_DECAY_EN
    check("sat_narrow_min", minMetric_n, 1);
    check("sat_wide_min", minMetric_w, 255);
`endif

    // symEn while busy: sticky overrun, pass unaffected.
    apply_reset();
    check("overrun_clear", overrun_w, 0);
    set_uniform(20, 40);
    pb1[2] = 90;
    run_pass(1'b0, 1'b1);
    check("overrun_set_w", overrun_w, 1);
    check("overrun_set_n", overrun_n, 1);
    run_pass(1'b1, 1'b0);
    check("overrun_sticky", overrun_w, 1);

    // Randomised passes against the reference model.
    apply_reset();
    for (int p = 0; p < 40; p++) begin
      decayFactor = 8'($urandom_range(0, 255));
      for (int s = 0; s < 4; s++) begin
        pb0[s] = $urandom_range(0, 255);
        pb1[s] = $urandom_range(0, 255);
      end
      run_pass(1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
